// File: rtl/sram_mem_ctrl_pkg.sv
// rtl/sram_mem_ctrl_pkg.sv - shared constants for the SRAM data-memory controller
//
// Purpose: FSM state encodings, default address-map parameters and the
// byte-offset helper used by sram_mem_ctrl.
package sram_mem_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Default address map and timing
    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned DEF_SRAM_AW   = 18;
    localparam int unsigned DEF_SRAM_WAIT = 2;

    // Offset of a byte address from the start of the SRAM window.
    // Modular on purpose: addresses below the base wrap to the top of the SRAM.
    function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit load/store sequencer over a 16-bit external SRAM
//
// Purpose: splits each MEM-stage word access into a low and a high halfword
// access, each lasting SRAM_WAIT cycles, and freezes the pipeline until done.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   wr_en, rd_en          store / load request, held by requester until ready
//   address, write_data   byte address and store data from the MEM stage
//   read_data             registered load result, valid while ready in DONE
//   ready                 1 = pipeline may advance
//   sram_addr             registered halfword address
//   sram_wdata            registered write halfword
//   sram_we_n             registered active-low write strobe
//   sram_rdata            asynchronous SRAM read halfword
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW   = DEF_SRAM_AW,
    parameter int unsigned SRAM_WAIT = DEF_SRAM_WAIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    output logic               sram_we_n,
    input  logic [15:0]        sram_rdata
);

    localparam int unsigned WIDX_W    = SRAM_AW - 1;
    localparam logic [3:0]  WAIT_LAST = 4'(SRAM_WAIT - 1);

    logic [1:0]        state;
    logic [3:0]        wcnt;
    logic              op_write;
    logic [WIDX_W-1:0] widx;
    logic [15:0]       wdata_hi;

    logic [31:0]       off;
    logic [WIDX_W-1:0] req_widx;
    logic              req;
    logic              phase_end;
    logic              unused_off;

    assign off        = byte_offset(address, 32'(BASE_ADDR));
    assign req_widx   = off[SRAM_AW:2];
    assign req        = wr_en | rd_en;
    assign phase_end  = (wcnt == WAIT_LAST);
    // Byte-lane bits and address bits above the SRAM window are dropped.
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    // Combinational so the freeze releases immediately when no request is
    // pending, including while reset is held.
    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = ~req;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wcnt       <= 4'd0;
            op_write   <= 1'b0;
            widx       <= '0;
            wdata_hi   <= 16'd0;
            read_data  <= 32'd0;
            sram_addr  <= '0;
            sram_wdata <= 16'd0;
            sram_we_n  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        // Everything the access needs is latched here so the
                        // requester's inputs may wander while frozen.
                        op_write   <= wr_en;
                        widx       <= req_widx;
                        wdata_hi   <= write_data[31:16];
                        wcnt       <= 4'd0;
                        sram_addr  <= {req_widx, 1'b0};
                        sram_wdata <= write_data[15:0];
                        sram_we_n  <= ~wr_en;
                        state      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (phase_end) begin
                        if (!op_write) begin
                            read_data[15:0] <= sram_rdata;
                        end
                        sram_addr  <= {widx, 1'b1};
                        sram_wdata <= wdata_hi;
                        wcnt       <= 4'd0;
                        state      <= ST_HI;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_HI: begin
                    if (phase_end) begin
                        if (!op_write) begin
                            read_data[31:16] <= sram_rdata;
                        end
                        sram_we_n <= 1'b1;
                        wcnt      <= 4'd0;
                        state     <= ST_DONE;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: begin
                    // DONE: one ready cycle, then back to IDLE regardless of request.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequences the data-memory resource for the MEM stage.
- Converts one 32-bit load/store into two 16-bit accesses on an external SRAM, with a programmable number of wait cycles per access.
- Holds the pipeline through `ready` until the word completes.
- Sits between the MEM stage (ALU result as address, Val_Rm as store data) and the off-chip SRAM. Replaces the single-cycle byte-array data memory.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.
- SRAM_WAIT, 2: cycles per SRAM halfword access. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  store request; held until ready.
- rd_en  in  1  load request; held until ready.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load result; registered.
- ready  out  1  1 = pipeline may advance; the hazard/freeze logic uses ~ready.
- sram_addr  out  SRAM_AW  halfword address; registered.
- sram_wdata  out  16  write halfword; registered.
- sram_we_n  out  1  SRAM write strobe, active-low; registered.
- sram_rdata  in  16  SRAM read halfword; combinational from sram_addr while sram_we_n=1.

Behaviour:
- Address map:
  - off = address - BASE_ADDR, 32-bit modular.
  - widx = off[SRAM_AW:2]; address bits [1:0] are ignored.
  - Low halfword is at {widx,1'b0}; high halfword is at {widx,1'b1}.
  - Out-of-range addresses wrap silently. No error output.
- FSM states: IDLE, LO, HI, DONE. Wait counter wcnt is 4 bits.
- IDLE:
  - ready = ~(wr_en|rd_en).
  - On a request, latch op (write wins if wr_en and rd_en are both 1), widx and write_data.
  - Next state LO; wcnt=0.
  - sram_addr <= {widx,0}; sram_wdata <= write_data[15:0]; sram_we_n <= ~op_write.
- LO:
  - ready=0. Lasts exactly SRAM_WAIT cycles.
  - On the last cycle (wcnt==SRAM_WAIT-1), a read captures read_data[15:0] <= sram_rdata.
  - Next state HI.
  - sram_addr <= {widx,1}; sram_wdata <= wdata_l[31:16]; sram_we_n stays at op value.
- HI:
  - ready=0. Lasts SRAM_WAIT cycles.
  - On the last cycle, a read captures read_data[31:16].
  - Next state DONE; sram_we_n <= 1.
- DONE:
  - ready=1 for exactly one cycle; read_data is valid.
  - Next state IDLE unconditionally.
  - A request seen in the following IDLE cycle is treated as a new access.
- Latency: request first seen in cycle 0 → ready=1 in cycle 2*SRAM_WAIT+1. Default SRAM_WAIT=2 gives 6 cycles, 5 of them frozen.
- Writes:
  - sram_we_n is low for every cycle of LO and HI.
  - Address and data are stable for the whole phase. They change only on phase-entry edges.
- read_data:
  - Updated only by reads.
  - Holds its value across writes and idle cycles.
  - Not masked by rd_en.
- Inputs changing mid-access are ignored because the access uses latched values. The requester must still hold the request until ready.
- Reset:
  - Async assertion forces state=IDLE, wcnt=0, read_data=0, sram_addr=0, sram_wdata=0, sram_we_n=1.
  - A mid-access reset aborts the access. A partial write (low half only) is permitted to remain in the SRAM.
  - ready is combinational: during reset with no request, ready=1.

Decomposition:
- Shared header `mem_defs.vh`:
  - state encodings: IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3;
  - BASE_ADDR default;
  - SRAM_AW default.
- Single module, no sub-module.
- The bench provides a behavioural SRAM model (sram_model): a 2^SRAM_AW x 16 array, written on posedge clk when sram_we_n=0, read asynchronously.

Test Plan:
- Store then load: write 0xDEADBEEF to address 1024, then read 1024. SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; read_data=0xDEADBEEF in the DONE cycle.
- Latency, SRAM_WAIT=2: rd_en rises at cycle 0. ready=0 for cycles 0–4 and ready=1 at cycle 5. Rerun with SRAM_WAIT=1: ready=1 at cycle 3.
- Unaligned and wrap addressing:
  - write 0x11223344 at address 1030: sram_addr 2 then 3; SRAM[2]=0x3344, SRAM[3]=0x1122.
  - write at address 0: sram_addr 0x3FE00 then 0x3FE01.
- Write priority and strobe: wr_en=rd_en=1 at address 1028 with data 0xCAFEF00D. A write occurs; sram_we_n is low for exactly 4 cycles; read_data is unchanged from its prior value.
- Reset mid-access: assert rst_n=0 during the HI phase of a write. sram_we_n=1 immediately, before any clock edge. State returns to IDLE; read_data=0. The next read of the same address returns the new low half and the old high half.
- Input change mid-access: change address and write_data during LO. The SRAM sees only the originally latched values.
